// File: rtl/cpu_sys_pkg.sv
// Shared CPU-system definitions: data-memory arbiter state encoding and default sizing.
// Default burst and guard lengths live here so every instance shares the same values.
package cpu_sys_pkg;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HOST_OWN  = 2'd1,
    CPU_GUARD = 2'd2
  } arb_state_t;

  localparam int HOST_BURST_DEF = 4;
  localparam int CPU_SLOTS_DEF  = 2;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one RAM port between the CPU (default owner) and a host that borrows it in bounded bursts.
// Latency: host grant is combinational while the host owns the RAM; read data returns one cycle after the grant.
// Backpressure: the CPU is stalled while the host owns the RAM; the host waits until host_gnt_o is high.
module dmem_arbiter
  import cpu_sys_pkg::*;
#(
  parameter int HOST_BURST = HOST_BURST_DEF,
  parameter int CPU_SLOTS  = CPU_SLOTS_DEF
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [14:0] cpu_addr_i,
  input  logic [15:0] cpu_data_i,
  input  logic        cpu_wr_en_i,
  output logic [15:0] cpu_data_o,
  output logic        cpu_stall_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [14:0] host_addr_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_gnt_o,
  output logic        host_rvalid_o,
  output logic [15:0] host_rdata_o,
  output logic [14:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [15:0] mem_rdata_i
);

  localparam logic [3:0] BURST_LAST = 4'(HOST_BURST);
  localparam logic [3:0] GUARD_LOAD = 4'(CPU_SLOTS);

  arb_state_t state;
  logic [3:0] burst_cnt;
  logic [3:0] guard_cnt;
  logic       host_own;

  assign host_own    = (state == HOST_OWN);
  assign cpu_stall_o = host_own;
  assign host_gnt_o  = host_own & host_req_i;
  assign mem_addr_o  = host_own ? host_addr_i  : cpu_addr_i;
  assign mem_wdata_o = host_own ? host_wdata_i : cpu_data_i;
  // Qualifying with reset kills a write in flight the moment reset asserts.
  assign mem_we_o    = reset_ni & (host_own ? (host_req_i & host_we_i) : cpu_wr_en_i);
  assign cpu_data_o  = mem_rdata_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= CPU_OWN;
      burst_cnt     <= '0;
      guard_cnt     <= '0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      host_rvalid_o <= host_gnt_o & ~host_we_i;
      if (host_gnt_o && !host_we_i) host_rdata_o <= mem_rdata_i;

      case (state)
        CPU_OWN: begin
          // Arbitration cycle: ownership flips but nothing is transferred yet.
          if (host_req_i) begin
            state     <= HOST_OWN;
            burst_cnt <= '0;
          end
        end
        HOST_OWN: begin
          if (host_req_i) burst_cnt <= burst_cnt + 4'd1;
          if (!host_req_i || (burst_cnt + 4'd1 == BURST_LAST)) begin
            state     <= CPU_GUARD;
            guard_cnt <= GUARD_LOAD;
          end
        end
        CPU_GUARD: begin
          guard_cnt <= guard_cnt - 4'd1;
          if (guard_cnt <= 4'd1) state <= CPU_OWN;
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: directed scenarios then random traffic against an ownership-window model.
module tb_dmem_arbiter;

  localparam int HB = 4;
  localparam int CS = 2;

  typedef struct {
    bit          gnt;
    bit          stall;
    bit          we;
    bit          rvalid;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] cpu_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] cpu_addr, host_addr, mem_addr;
  logic [15:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic        cpu_we, cpu_stall, host_req, host_we, host_gnt, host_rvalid, mem_we;

  logic        h1_req, h1_gnt, h1_stall, h1_rvalid, m1_we;
  logic [15:0] h1_rdata, c1_rdata, m1_wdata;
  logic [14:0] m1_addr;

  logic [15:0] ram [0:32767];
  logic [15:0] shadow [logic [14:0]];
  exp_t        exp_q [$];
  logic [15:0] rd_q [$];
  int          gnt_log [$];

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  // Reference model: host ownership window and CPU guard window, counted in cycles.
  bit m_host    = 1'b0;
  int m_used    = 0;
  int m_guard   = 0;
  bit m_rd_pend = 1'b0;
  int m_gnts    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.HOST_BURST(HB), .CPU_SLOTS(CS)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata), .cpu_wr_en_i(cpu_we),
    .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.HOST_BURST(1), .CPU_SLOTS(1)) dut1 (
    .clk_i(clk), .reset_ni(reset_n),
    .cpu_addr_i(15'h0), .cpu_data_i(16'h0), .cpu_wr_en_i(1'b0),
    .cpu_data_o(c1_rdata), .cpu_stall_o(h1_stall),
    .host_req_i(h1_req), .host_we_i(1'b0), .host_addr_i(15'h0),
    .host_wdata_i(16'h0), .host_gnt_o(h1_gnt), .host_rvalid_o(h1_rvalid),
    .host_rdata_o(h1_rdata),
    .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata), .mem_we_o(m1_we),
    .mem_rdata_i(16'h0)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sh_rd(input logic [14:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0;
  endfunction

  // Drive one cycle of inputs and record what the spec says must happen in it.
  task automatic stim(input bit req, input bit hwe, input logic [14:0] haddr, input logic [15:0] hwd,
                      input bit cwe, input logic [14:0] caddr, input logic [15:0] cwd);
    exp_t e;
    host_req = req; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    e.rvalid = m_rd_pend;
    e.stall  = m_host;
    e.gnt    = m_host && req;
    e.addr   = m_host ? haddr : caddr;
    e.wdata  = m_host ? hwd : cwd;
    e.we     = m_host ? (req && hwe) : cwe;
    e.cpu_rd = sh_rd(e.addr);
    m_rd_pend = e.gnt && !hwe;
    if (m_rd_pend) rd_q.push_back(sh_rd(haddr));
    if (e.we) shadow[e.addr] = e.wdata;
    if (e.gnt) m_gnts++;
    if (m_host) begin
      if (req) m_used++;
      if (!req || m_used == HB) begin
        m_host  = 1'b0;
        m_guard = CS;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else if (req) begin
      m_host = 1'b1;
      m_used = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      stim(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'($urandom_range(0, 31)), 16'h0);
      tick();
    end
  endtask

  // Monitor: compares every driven cycle against its queued expectation.
  exp_t        mon_e;
  logic [15:0] mon_d;
  always @(negedge clk) begin
    if (host_gnt) gnt_log.push_back(tb_cyc);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (reset_n) begin
        chk("host_gnt", 32'(host_gnt), 32'(mon_e.gnt));
        chk("cpu_stall", 32'(cpu_stall), 32'(mon_e.stall));
        chk("mem_we", 32'(mem_we), 32'(mon_e.we));
        chk("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
        if (mon_e.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
        chk("cpu_data", 32'(cpu_rdata), 32'(mon_e.cpu_rd));
        chk("host_rvalid", 32'(host_rvalid), 32'(mon_e.rvalid));
        if (mon_e.rvalid) begin
          mon_d = rd_q.pop_front();
          if (host_rvalid) chk("host_rdata", 32'(host_rdata), 32'(mon_d));
        end
      end
    end
  end

  initial begin
    int start;
    int g0;
    int guard;
    int exp_idx [10] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16};

    for (int i = 0; i < 32768; i++) ram[i] = 16'h0;
    reset_n = 1'b0; h1_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 15'h3; host_wdata = 16'hFFFF;
    cpu_we = 1'b1; cpu_addr = 15'h3; cpu_wdata = 16'hFFFF;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_gnt", 32'(host_gnt), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    host_req = 1'b0; cpu_we = 1'b0;
    reset_n = 1'b1;
    tick();

    // CPU write with host idle
    stim(1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 15'h0005, 16'h1234);
    #1;
    chk("cpu_wr_we", 32'(mem_we), 1);
    chk("cpu_wr_addr", 32'(mem_addr), 32'h5);
    chk("cpu_wr_stall", 32'(cpu_stall), 0);
    tick();
    idle(2);

    // Host single read of 0x0005
    stim(1'b1, 1'b0, 15'h0005, 16'h0, 1'b0, 15'h1, 16'h0); tick();
    stim(1'b1, 1'b0, 15'h0005, 16'h0, 1'b0, 15'h1, 16'h0); tick();
    idle(6);
    chk("single_read_data", 32'(host_rdata), 32'h1234);

    // Continuous host writes: 10 transfers in groups of HB
    gnt_log.delete();
    start = tb_cyc;
    g0 = m_gnts;
    guard = 0;
    while (m_gnts - g0 < 10 && guard < 60) begin
      stim(1'b1, 1'b1, 15'h0010 + 15'(m_gnts - g0), 16'($urandom), 1'b0,
           15'($urandom_range(0, 31)), 16'h0);
      tick();
      guard++;
    end
    chk("burst_gnt_count", 32'(gnt_log.size()), 10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      chk("burst_gnt_slot", 32'(gnt_log[i] - start), 32'(exp_idx[i]));
    idle(4);

    // Host request collides with CPU write to 0x4000
    stim(1'b1, 1'b0, 15'h4000, 16'h0, 1'b1, 15'h4000, 16'hBEEF);
    #1;
    chk("collide_cpu_we", 32'(mem_we), 1);
    chk("collide_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    stim(1'b1, 1'b0, 15'h4000, 16'h0, 1'b1, 15'h4000, 16'h5555); tick();
    idle(6);
    chk("collide_read_data", 32'(host_rdata), 32'hBEEF);

    // Reset during the second write of a burst
    stim(1'b1, 1'b1, 15'h0100, 16'hA1A1, 1'b0, 15'h0, 16'h0); tick();
    stim(1'b1, 1'b1, 15'h0100, 16'hA1A1, 1'b0, 15'h0, 16'h0); tick();
    stim(1'b1, 1'b1, 15'h0101, 16'hB2B2, 1'b0, 15'h0, 16'h0);
    #1;
    chk("pre_rst_we", 32'(mem_we), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 0);
    shadow.delete(15'h0101);
    host_req = 1'b0; host_we = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    m_host = 1'b0; m_used = 0; m_guard = 0; m_rd_pend = 1'b0;
    rd_q.delete();
    #1;
    chk("post_rst_rvalid", 32'(host_rvalid), 0);
    chk("post_rst_stall", 32'(cpu_stall), 0);
    tick();
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stim($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 15'h4000 : 15'($urandom_range(0, 31)), 16'($urandom),
           $urandom_range(0, 9) < 3,
           ($urandom_range(0, 3) == 0) ? 15'h4000 : 15'($urandom_range(0, 31)), 16'($urandom));
      tick();
    end
    idle(8);

    // HOST_BURST=1, CPU_SLOTS=1 instance: grant every third cycle
    h1_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("b1_gnt", 32'(h1_gnt), 32'(i % 3 == 1));
      chk("b1_stall", 32'(h1_stall), 32'(i % 3 == 1));
      @(posedge clk); #1;
    end
    h1_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter HOST_BURST, default 4: maximum host transfers per ownership period (1..15).
REQ-002 SHALL have parameter CPU_SLOTS, default 2: guaranteed CPU cycles after each host period (1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous reset, active-low
REQ-004 SHALL have the following CPU-side ports:
- cpu_addr_i  in  15  CPU data address
- cpu_data_i  in  16  CPU write data
- cpu_wr_en_i  in  1  CPU write enable
- cpu_data_o  out  16  CPU read data
- cpu_stall_o  out  1  hold CPU (PC, A/D load enables)
REQ-005 SHALL have the following host-side ports:
- host_req_i  in  1  host request valid
- host_we_i  in  1  host write
- host_addr_i  in  15  host address
- host_wdata_i  in  16  host write data
- host_gnt_o  out  1  host transfer accepted this cycle
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  16  host read data
REQ-006 SHALL have the following memory ports:
- mem_addr_o  out  15  RAM address
- mem_wdata_o  out  16  RAM write data
- mem_we_o  out  1  RAM write enable
- mem_rdata_i  in  16  RAM read data (combinational read, synchronous write)

Function
REQ-007 SHALL implement FSM states CPU_OWN, HOST_OWN, CPU_GUARD.
REQ-008 CPU_OWN: mem_* SHALL be driven from cpu_*; cpu_stall_o=0; host_gnt_o=0.
REQ-009 CPU_OWN with host_req_i=1 at a clock edge SHALL move to HOST_OWN, clear burst_cnt, and perform no host transfer in that cycle.
REQ-010 HOST_OWN: cpu_stall_o=1; mem_* SHALL be driven from host_*; host_gnt_o=host_req_i (combinational); mem_we_o=host_req_i&host_we_i; cpu_wr_en_i SHALL be ignored.
REQ-011 Each granted transfer SHALL increment burst_cnt; on the edge where the grant makes burst_cnt reach HOST_BURST, or in any HOST_OWN cycle with host_req_i=0, the FSM SHALL move to CPU_GUARD and load guard_cnt=CPU_SLOTS.
REQ-012 CPU_GUARD SHALL behave as CPU_OWN with host_gnt_o=0 regardless of host_req_i; guard_cnt SHALL decrement each cycle; at guard_cnt==1 the FSM SHALL move to CPU_OWN.
REQ-013 A granted host read SHALL register mem_rdata_i into host_rdata_o and assert host_rvalid_o for exactly one cycle after the grant; host_rdata_o SHALL hold otherwise.
REQ-014 cpu_data_o SHALL equal mem_rdata_i at all times; it is meaningful only when cpu_stall_o=0.
REQ-015 A host request held continuously SHALL receive exactly HOST_BURST grants, then CPU_SLOTS stall-free cycles, then one arbitration cycle, then further grants (no CPU starvation, no host starvation).
REQ-016 Simultaneous CPU write and host request in CPU_OWN: the CPU write SHALL commit; the host waits.

Reset
REQ-017 While reset_ni=0, the block SHALL hold state=CPU_OWN, burst_cnt=0, guard_cnt=0, host_rvalid_o=0, host_rdata_o=0, cpu_stall_o=0, and host_gnt_o=0.
REQ-018 A reset asserted mid-burst SHALL deassert mem_we_o immediately (asynchronously) and drop any pending host_rvalid_o.

Structure
REQ-019 The state encoding and the HOST_BURST/CPU_SLOTS defaults SHALL reside in a shared package, cpu_sys_pkg.
REQ-020 The block SHALL be a single module with no sub-module; the counters and FSM are local, and the top level gates the CPU register and PC load enables with cpu_stall_o.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then CPU writes 0x1234 to 0x0005 with host idle -> mem_we_o=1, mem_addr_o=0x0005, cpu_stall_o=0.
- Host single read of 0x0005 -> one arbitration cycle, host_gnt_o pulse, next cycle host_rvalid_o=1, host_rdata_o=0x1234, then CPU_GUARD for 2 cycles.
- Host holds host_req_i for 10 writes -> grants occur in groups of 4 separated by exactly 3 non-granting cycles; cpu_stall_o=0 during each guard.
- Host request in the same cycle as a CPU write to 0x4000 -> the CPU write commits, then the host is granted after one cycle.
- reset_ni pulled low during the 2nd write of a burst -> mem_we_o=0 immediately; after release: state CPU_OWN, host_rvalid_o=0.
- HOST_BURST=1, CPU_SLOTS=1, continuous host requests -> grant every 3rd cycle.
